// File: rtl/scene_pkg.sv
// Shared types and constants for the scene-constant register bank.
// Word indices describe where each constant lives in the 30-word scene packet.
`timescale 1ns/1ps
package scene_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, PENDING} scene_state_t;

   localparam int NUM_SCENE_WORDS = 30;
   localparam int SCENE_WORD_W    = 16;
   localparam int BPW             = SCENE_WORD_W / 8;
   localparam int TOTAL_BYTES     = NUM_SCENE_WORDS * BPW;
   localparam int IDX_W           = $clog2(TOTAL_BYTES + 1);

   // First word of each scene field; vectors are XYZ triples, VP rows are four words
   localparam int W_V0     = 0;
   localparam int W_V1     = 3;
   localparam int W_V2     = 6;
   localparam int W_N      = 9;
   localparam int W_L      = 12;
   localparam int W_VP_R0  = 15;
   localparam int W_VP_R1  = 19;
   localparam int W_VP_R3  = 23;
   localparam int W_V3     = 27;

endpackage

// File: rtl/scene_reg_bank.sv
// Byte-serial loader with shadow/active double buffering for scene constants.
// The active bank changes only by a whole-packet commit, so the shader never sees a partial update.
`timescale 1ns/1ps
module scene_reg_bank
   import scene_pkg::*;
#(
   parameter int NUM_WORDS      = NUM_SCENE_WORDS,
   parameter int WORD_W         = SCENE_WORD_W,
   parameter int CHECKSUM_EN    = 1,
   parameter int COMMIT_ON_SYNC = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        byte_valid,
   input  logic [7:0]                  byte_data,
   input  logic                        sof,
   input  logic                        frame_sync,
   output logic [NUM_WORDS*WORD_W-1:0] regs_o,
   output logic                        commit_o,
   output logic                        err_o,
   output logic                        pending_o,
   output logic                        busy_o
);

   localparam int BYTES_PER_WORD = WORD_W / 8;
   localparam int TOTAL          = NUM_WORDS * BYTES_PER_WORD;
   localparam int CNT_W          = $clog2(TOTAL + 1);
   localparam int BANK_W         = NUM_WORDS * WORD_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

   scene_state_t      state, state_nxt;
   logic [CNT_W-1:0]  idx, idx_nxt, wr_idx;
   logic [7:0]        acc, acc_nxt, acc_base;
   logic [BANK_W-1:0] shadow;
   logic              load_byte, do_commit, err_nxt;

   // sof restarts the packet regardless of state; a byte arriving with it is byte 0
   assign wr_idx   = sof ? '0 : idx;
   assign acc_base = sof ? '0 : acc;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      acc_nxt   = acc;
      load_byte = 1'b0;
      do_commit = 1'b0;
      err_nxt   = 1'b0;
      if (sof) begin
         state_nxt = LOAD;
         idx_nxt   = '0;
         acc_nxt   = '0;
         load_byte = byte_valid;
      end else begin
         case (state)
            LOAD:    load_byte = byte_valid;
            CHECK: begin
               if (byte_valid) begin
                  if (byte_data == acc) begin
                     state_nxt = PENDING;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
            PENDING: begin
               // Extra bytes here are an overrun: flagged and dropped, data kept
               err_nxt = byte_valid;
               if ((COMMIT_ON_SYNC == 0) || frame_sync) begin
                  do_commit = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: ;
         endcase
      end
      if (load_byte) begin
         acc_nxt = acc_base ^ byte_data;
         idx_nxt = wr_idx + CNT_W'(1);
         if (wr_idx == LAST_IDX)
            state_nxt = (CHECKSUM_EN != 0) ? CHECK : PENDING;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         acc      <= '0;
         shadow   <= '0;
         regs_o   <= '0;
         commit_o <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         acc      <= acc_nxt;
         commit_o <= do_commit;
         err_o    <= err_nxt;
         // Commit reads shadow before this edge's write lands
         if (do_commit)
            regs_o <= shadow;
         // Words are little-endian and byte-aligned, so byte i sits at bit 8*i
         for (int b = 0; b < TOTAL; b++) begin
            if (load_byte && (wr_idx == CNT_W'(b)))
               shadow[b*8 +: 8] <= byte_data;
         end
      end
   end

   assign pending_o = (state == PENDING);
   assign busy_o    = (state == LOAD) || (state == CHECK);

endmodule
